seq_mult_ctrl: RTL and testbench
================================

Name: seq_mult_ctrl

Overview:
Control FSM for the 32-bit shift-add sequential multiplier datapath. It accepts a start handshake and loads the operand registers. It then walks the multiplier bits LSB-first, issuing add (rs_load) and shift (rs_shr) strobes, and holds a done flag until the result is acknowledged. It sits beside the datapath in the multiplier top and drives all of the datapath's control inputs.

Parameters:
WIDTH, 32, operand width; must match datapath (product is 2*WIDTH).
CNT_W, $clog2(WIDTH), bit-index counter width.

Ports:
clk_i  input  1  clock
rst_n_i  input  1  reset, asynchronous, active-low
start_i  input  1  request new multiply; accepted when start_i & ready_o
ack_i  input  1  consumer acknowledges product while done_o=1
abort_i  input  1  synchronous abort of the operation in flight
mr_i  input  WIDTH  multiplier register value from datapath (mr_o)
ready_o  output  1  controller can accept start_i
busy_o  output  1  operation in progress (LOAD/EVAL/SHIFT)
done_o  output  1  product_o on datapath is valid
mr_ld_o  output  1  load multiplier register
md_ld_o  output  1  load multiplicand register
rs_clear_o  output  1  clear running-sum register
rs_load_o  output  1  add multiplicand into running-sum upper half
rs_shr_o  output  1  shift running sum right by 1
bit_idx_o  output  CNT_W  current multiplier bit under evaluation (debug)

Behaviour:
- Reset (async, rst_n_i=0): state=IDLE, bit_idx=0, all strobes 0, done_o=0, busy_o=0, ready_o=1 (combinational from IDLE).
- States: IDLE, LOAD, EVAL, SHIFT, DONE. All strobes are Moore/Mealy-decoded from the current state. At most one of rs_clear/rs_load/rs_shr is high in any cycle.
- IDLE: ready_o=1. If start_i=1, go to LOAD.
- LOAD (1 cycle): mr_ld_o=md_ld_o=rs_clear_o=1, bit_idx<=0, go to EVAL.
- EVAL: examine mr_i[bit_idx] (the registered value, valid from the cycle after LOAD).
  - Bit = 1: rs_load_o=1, go to SHIFT.
  - Bit = 0: rs_shr_o=1. If bit_idx==WIDTH-1, go to DONE; else bit_idx++ and stay in EVAL.
- SHIFT: rs_shr_o=1. If bit_idx==WIDTH-1, go to DONE; else bit_idx++ and go to EVAL.
- DONE: done_o=1, ready_o=1.
  - ack_i=1 and start_i=0: go to IDLE.
  - start_i=1 (with or without ack_i): treated as implicit ack, go to LOAD (back-to-back operation).
  - Otherwise hold DONE indefinitely. Datapath is not strobed, so product is stable.
- Latency, start accepted to done_o high: 1 + WIDTH + popcount(multiplier) cycles. Range 33..65 for WIDTH=32.
- busy_o=1 in LOAD/EVAL/SHIFT. start_i is ignored while busy_o=1 (ready_o=0).
- abort_i has priority over all transitions in LOAD/EVAL/SHIFT/DONE: next state=IDLE, no strobes issued in the abort cycle, bit_idx<=0. Datapath contents are left as-is and are don't-care. abort_i in IDLE has no effect.
- Async reset mid-operation returns to IDLE immediately. The next operation starts cleanly because LOAD asserts rs_clear_o.
- bit_idx never wraps during an operation. Terminal compare is against WIDTH-1.

Decomposition:
- Package seq_mult_pkg holds:
  - WIDTH default constant.
  - state enum type seq_mult_state_e {IDLE, LOAD, EVAL, SHIFT, DONE}.
  - CNT_W derivation.
- No sub-module: the FSM and bit counter live in one module.
- Top seq_mult_top (datapath + seq_mult_ctrl) is the verification DUT.

Test Plan:
- Multiplicand=5, multiplier=3, start pulse: done_o rises 35 cycles after acceptance; product=0x0000_0000_0000_000F; rs_load_o pulses exactly 2 times.
- Multiplier=0, multiplicand=0xDEADBEEF: done at 33 cycles, product=0, rs_load_o never asserted.
- Both operands 0xFFFFFFFF: done at 65 cycles, product=0xFFFF_FFFE_0000_0001.
- start_i held high during busy: ignored. In DONE, start_i with new operands 7×6 launches LOAD next cycle and yields product=42 after 1+32+2 more cycles.
- abort_i asserted at cycle 10 of 0x12345678×0x9ABCDEF0: IDLE next cycle, ready_o=1, done_o never asserted. A following 2×2 run gives product=4.
- rst_n_i dropped mid-operation: all strobes and done_o go 0 asynchronously. After release, 0x10000×0x10000 gives 0x1_0000_0000.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared width constants and controller state type for the
// shift-add sequential multiplier.
package seq_mult_pkg;

    localparam int WIDTH = 32;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_w(WIDTH);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        EVAL,
        SHIFT,
        DONE
    } seq_mult_state_e;

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control FSM for the shift-add sequential multiplier: walks the
// multiplier LSB-first and strobes the datapath add/shift controls.
module seq_mult_ctrl #(
    parameter int WIDTH = seq_mult_pkg::WIDTH,
    parameter int CNT_W = seq_mult_pkg::cnt_w(WIDTH)
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             ack_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] mr_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             mr_ld_o,
    output logic             md_ld_o,
    output logic             rs_clear_o,
    output logic             rs_load_o,
    output logic             rs_shr_o,
    output logic [CNT_W-1:0] bit_idx_o
);

    import seq_mult_pkg::*;

    seq_mult_state_e  state;
    seq_mult_state_e  state_nxt;
    logic [CNT_W-1:0] bit_idx;
    logic [CNT_W-1:0] bit_idx_nxt;
    logic             last;

    // Terminal bit: the counter stops here instead of wrapping.
    assign last      = (bit_idx == CNT_W'(WIDTH - 1));
    assign bit_idx_o = bit_idx;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            bit_idx <= '0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        ready_o     = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;
        mr_ld_o     = 1'b0;
        md_ld_o     = 1'b0;
        rs_clear_o  = 1'b0;
        rs_load_o   = 1'b0;
        rs_shr_o    = 1'b0;

        unique case (state)
            IDLE: begin
                ready_o = 1'b1;
                if (start_i) begin
                    state_nxt = LOAD;
                end
            end

            LOAD: begin
                busy_o      = 1'b1;
                bit_idx_nxt = '0;
                if (abort_i) begin
                    state_nxt = IDLE;
                end else begin
                    mr_ld_o    = 1'b1;
                    md_ld_o    = 1'b1;
                    rs_clear_o = 1'b1;
                    state_nxt  = EVAL;
                end
            end

            EVAL: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_nxt   = IDLE;
                    bit_idx_nxt = '0;
                end else if (mr_i[bit_idx]) begin
                    rs_load_o = 1'b1;
                    state_nxt = SHIFT;
                end else begin
                    // Zero bit: shift only, stay in EVAL for the next bit.
                    rs_shr_o = 1'b1;
                    if (last) begin
                        state_nxt = DONE;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                    end
                end
            end

            SHIFT: begin
                busy_o = 1'b1;
                if (abort_i) begin
                    state_nxt   = IDLE;
                    bit_idx_nxt = '0;
                end else begin
                    rs_shr_o = 1'b1;
                    if (last) begin
                        state_nxt = DONE;
                    end else begin
                        bit_idx_nxt = bit_idx + 1'b1;
                        state_nxt   = EVAL;
                    end
                end
            end

            DONE: begin
                done_o  = 1'b1;
                ready_o = 1'b1;
                if (abort_i) begin
                    state_nxt   = IDLE;
                    bit_idx_nxt = '0;
                end else if (start_i) begin
                    // New start doubles as the ack for the held product.
                    state_nxt = LOAD;
                end else if (ack_i) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt   = IDLE;
                bit_idx_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Bench for seq_mult_ctrl: behavioural datapath plus an expected-step
// queue model, checked every cycle, with directed operand vectors.
module tb_seq_mult_ctrl;

    localparam int W  = 32;
    localparam int CW = 5;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          ack   = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  op_mr = '0;
    logic [W-1:0]  op_md = '0;

    logic [W-1:0]  dp_mr = '0;
    logic [W-1:0]  dp_md = '0;
    logic [64:0]   dp_rs = '0;

    logic          ready_o, busy_o, done_o;
    logic          mr_ld_o, md_ld_o, rs_clear_o, rs_load_o, rs_shr_o;
    logic [CW-1:0] bit_idx_o;
    logic [4:0]    strb;

    always #5 clk = ~clk;

    seq_mult_ctrl dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .start_i    (start),
        .ack_i      (ack),
        .abort_i    (abort),
        .mr_i       (dp_mr),
        .ready_o    (ready_o),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .mr_ld_o    (mr_ld_o),
        .md_ld_o    (md_ld_o),
        .rs_clear_o (rs_clear_o),
        .rs_load_o  (rs_load_o),
        .rs_shr_o   (rs_shr_o),
        .bit_idx_o  (bit_idx_o)
    );

    assign strb = {mr_ld_o, md_ld_o, rs_clear_o, rs_load_o, rs_shr_o};

    // Behavioural shift-add datapath driven by the controller strobes.
    always @(posedge clk) begin
        if (mr_ld_o) dp_mr <= op_mr;
        if (md_ld_o) dp_md <= op_md;
        if (rs_clear_o)
            dp_rs <= '0;
        else if (rs_load_o)
            dp_rs[64:32] <= {1'b0, dp_rs[63:32]} + {1'b0, dp_md};
        else if (rs_shr_o)
            dp_rs <= dp_rs >> 1;
    end

    int n_cmp   = 0;
    int n_bad   = 0;
    int n_loads = 0;
    int n_done  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: one entry per busy cycle, built from the multiplier bits.
    typedef struct {
        logic clr;
        logic ld;
        logic shr;
        int   idx;
    } step_t;

    step_t mq[$];
    bit    m_done = 1'b0;

    function automatic void build(input logic [W-1:0] b);
        mq.delete();
        mq.push_back('{clr:1'b1, ld:1'b0, shr:1'b0, idx:-1});
        for (int i = 0; i < W; i++) begin
            if (b[i])
                mq.push_back('{clr:1'b0, ld:1'b1, shr:1'b0, idx:i});
            mq.push_back('{clr:1'b0, ld:1'b0, shr:1'b1, idx:i});
        end
    endfunction

    // Inputs as seen by the controller at the last rising edge.
    logic         p_vld = 1'b0;
    logic         p_start, p_ack, p_abort;
    logic [W-1:0] p_mr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld <= 1'b0;
        end else begin
            p_vld   <= 1'b1;
            p_start <= start;
            p_ack   <= ack;
            p_abort <= abort;
            p_mr    <= op_mr;
        end
    end

    logic       e_busy;
    logic       g;
    logic [4:0] e_str;

    initial forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_done = 1'b0;
        end else begin
            if (p_vld) begin
                if (mq.size() != 0) begin
                    if (p_abort) begin
                        mq.delete();
                    end else begin
                        void'(mq.pop_front());
                        if (mq.size() == 0) m_done = 1'b1;
                    end
                end else if (m_done) begin
                    if (p_abort) m_done = 1'b0;
                    else if (p_start) begin
                        build(p_mr);
                        m_done = 1'b0;
                    end else if (p_ack) m_done = 1'b0;
                end else if (p_start) begin
                    build(p_mr);
                end
            end
            e_busy = (mq.size() != 0);
            e_str  = '0;
            if (e_busy) begin
                g     = !abort;
                e_str = {mq[0].clr & g, mq[0].clr & g, mq[0].clr & g,
                         mq[0].ld & g, mq[0].shr & g};
                if (mq[0].idx >= 0)
                    chk("bit_idx", bit_idx_o, mq[0].idx);
            end
            chk("flags", {ready_o, busy_o, done_o},
                {!e_busy, e_busy, m_done});
            chk("strobes", strb, e_str);
            if (m_done) chk("done_idx", bit_idx_o, W - 1);
            if (rs_load_o) n_loads++;
            if (done_o) n_done++;
        end
    end

    task automatic start_op(input logic [W-1:0] md, input logic [W-1:0] mr,
                            input bit hold);
        logic r;
        int   c;
        @(posedge clk);
        #2;
        op_md   = md;
        op_mr   = mr;
        start   = 1'b1;
        n_loads = 0;
        c       = 0;
        r       = 1'b0;
        while (!r && c < 100) begin
            @(negedge clk);
            r = ready_o;
            @(posedge clk);
            c++;
        end
        #2;
        if (!r) chk("accept_timeout", 0, 1);
        if (!hold) start = 1'b0;
    endtask

    // Call right after the accepting edge; counts busy cycles to done.
    task automatic wait_done(input string name, input int lat);
        int c;
        c = 0;
        while (c < 200) begin
            @(negedge clk);
            #1;
            if (done_o) break;
            c++;
        end
        chk({name, "_latency"}, c, lat);
    endtask

    task automatic do_ack();
        @(posedge clk);
        #2 ack = 1'b1;
        @(posedge clk);
        #2 ack = 1'b0;
        @(negedge clk);
        #1;
        chk("ack_idle", {ready_o, done_o}, 2'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_flags", {ready_o, busy_o, done_o}, 3'b100);
        chk("rst_strobes", strb, 0);
        chk("rst_idx", bit_idx_o, 0);

        start_op(32'd5, 32'd3, 1'b0);
        wait_done("m5x3", 35);
        chk("m5x3_product", dp_rs[63:0], 64'h0000_0000_0000_000F);
        chk("m5x3_loads", n_loads, 2);
        repeat (3) @(negedge clk);
        #1;
        chk("m5x3_hold", {done_o, dp_rs[63:0]}, {1'b1, 64'hF});
        do_ack();

        start_op(32'hDEAD_BEEF, 32'd0, 1'b0);
        wait_done("mzero", 33);
        chk("mzero_product", dp_rs[63:0], 64'd0);
        chk("mzero_loads", n_loads, 0);
        do_ack();

        // start stays high for the whole run, then relaunches from DONE.
        start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("mff", 65);
        chk("mff_product", dp_rs[63:0], 64'hFFFF_FFFE_0000_0001);
        chk("mff_loads", n_loads, 32);
        op_md   = 32'd7;
        op_mr   = 32'd6;
        n_loads = 0;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done("b2b", 35);
        chk("b2b_product", dp_rs[63:0], 64'd42);
        chk("b2b_loads", n_loads, 2);
        do_ack();

        start_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (9) @(posedge clk);
        #2 abort = 1'b1;
        @(negedge clk);
        #1;
        chk("abort_strobes", strb, 0);
        @(posedge clk);
        #2 abort = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_idle", {ready_o, busy_o, done_o}, 3'b100);
        chk("abort_idx", bit_idx_o, 0);
        n_done = 0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", n_done, 0);

        start_op(32'd2, 32'd2, 1'b0);
        wait_done("m2x2", 34);
        chk("m2x2_product", dp_rs[63:0], 64'd4);
        @(posedge clk);
        #2 abort = 1'b1;
        @(posedge clk);
        #2 abort = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_done", {ready_o, busy_o, done_o}, 3'b100);

        start_op(32'd3, 32'd5, 1'b0);
        repeat (8) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_strobes", strb, 0);
        chk("arst_flags", {ready_o, busy_o, done_o}, 3'b100);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        start_op(32'h0001_0000, 32'h0001_0000, 1'b0);
        wait_done("m64k", 34);
        chk("m64k_product", dp_rs[63:0], 64'h0000_0001_0000_0000);
        do_ack();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
